// File: rtl/uart_prog_loader_if.sv
// Purpose: byte stream in from the UART receiver, memory write port and load status out.
// Latency: none, this is only a bundle of wires.
// Backpressure: none; the byte side is a strobe, and the memory side is a fire-and-forget write pulse.
interface uart_prog_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;

    // System side: feeds bytes, observes writes and status
    modport master (
        output rx_data, rx_valid,
        input  mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
    );

    // Loader side
    modport slave (
        input  rx_data, rx_valid,
        output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
    );
endinterface

// File: rtl/uart_prog_loader.sv
// Purpose: parses LEN16 + 4*LEN byte frames into 32-bit LE memory writes; CHECKSUM_EN adds a trailing XOR byte.
// Latency: mem_we one cycle after a word's 4th byte; load_done one cycle after the frame's final byte.
// Backpressure: none; every rx_valid byte is consumed, and an idle gap of TIMEOUT cycles aborts the frame.
module uart_prog_loader #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       TIMEOUT   = 2000000
) (
    input  logic              clk,
    input  logic              reset,
    uart_prog_loader_if.slave bus
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {LEN0, LEN1, DATA, CHK, DONE} state_t;
`else
    typedef enum logic [2:0] {LEN0, LEN1, DATA, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [15:0]       len_q;
    logic [1:0]        byte_idx_q;
    logic [15:0]       word_idx_q;
    logic [23:0]       asm_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              hold_q;
    logic              done_q;
    logic              err_q;
`ifdef CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic take_len0, take_len1, take_byte, fin_ok, fin_err;
    logic tmo_hit, last_word, in_frame;

    // Timer reaches its limit on the TIMEOUT-th consecutive idle cycle
    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign last_word = (byte_idx_q == 2'd3) && (word_idx_q == len_q - 16'd1);
    assign in_frame  = (state_q != LEN0) && (state_q != DONE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= LEN0;
        else        state_q <= state_d;
    end

    // Next-state and per-cycle action strobes
    always_comb begin
        state_d   = state_q;
        take_len0 = 1'b0;
        take_len1 = 1'b0;
        take_byte = 1'b0;
        fin_ok    = 1'b0;
        fin_err   = 1'b0;
        case (state_q)
            LEN0, DONE: begin
                // DONE lasts one cycle; a byte arriving then already opens the next frame
                state_d = LEN0;
                if (bus.rx_valid) begin
                    take_len0 = 1'b1;
                    state_d   = LEN1;
                end
            end
            LEN1: begin
                if (bus.rx_valid) begin
                    take_len1 = 1'b1;
                    if ({bus.rx_data, len_q[7:0]} == 16'd0) begin
                        fin_ok  = 1'b1;
                        state_d = LEN0;
                    end else begin
                        state_d = DATA;
                    end
                end else if (tmo_hit) begin
                    fin_err = 1'b1;
                    state_d = LEN0;
                end
            end
            DATA: begin
                if (bus.rx_valid) begin
                    take_byte = 1'b1;
                    if (last_word) begin
`ifdef CHECKSUM_EN
                        state_d = CHK;
`else
                        fin_ok  = 1'b1;
                        state_d = DONE;
`endif
                    end
                end else if (tmo_hit) begin
                    fin_err = 1'b1;
                    state_d = LEN0;
                end
            end
`ifdef CHECKSUM_EN
            CHK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == csum_q) begin
                        fin_ok  = 1'b1;
                        state_d = DONE;
                    end else begin
                        fin_err = 1'b1;
                        state_d = LEN0;
                    end
                end else if (tmo_hit) begin
                    fin_err = 1'b1;
                    state_d = LEN0;
                end
            end
`endif
            default: state_d = LEN0;
        endcase
    end

    // Datapath: length, word assembly, write port, status flags, idle timer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q       <= '0;
            byte_idx_q  <= '0;
            word_idx_q  <= '0;
            asm_q       <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= fin_ok;

            if (take_len0) begin
                len_q[7:0] <= bus.rx_data;
                err_q      <= 1'b0;
                hold_q     <= 1'b1;
            end
            if (take_len1) begin
                len_q[15:8] <= bus.rx_data;
                byte_idx_q  <= '0;
                word_idx_q  <= '0;
`ifdef CHECKSUM_EN
                csum_q      <= '0;
`endif
            end
            if (take_byte) begin
                byte_idx_q <= byte_idx_q + 2'd1;
`ifdef CHECKSUM_EN
                csum_q     <= csum_q ^ bus.rx_data;
`endif
                case (byte_idx_q)
                    2'd0: asm_q[7:0]   <= bus.rx_data;
                    2'd1: asm_q[15:8]  <= bus.rx_data;
                    2'd2: asm_q[23:16] <= bus.rx_data;
                    default: begin
                        // Separate output register frees asm_q for the next word immediately
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= {bus.rx_data, asm_q};
                        mem_addr_q  <= BASE_ADDR + ADDR_W'({word_idx_q, 2'b00});
                        word_idx_q  <= word_idx_q + 16'd1;
                    end
                endcase
            end
            if (fin_ok) hold_q <= 1'b0;
            if (fin_err) begin
                hold_q <= 1'b0;
                err_q  <= 1'b1;
            end

            if (bus.rx_valid || !in_frame || tmo_hit) tmo_q <= '0;
            else                                      tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.load_done  = done_q;
    assign bus.load_error = err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Purpose: directed checks of the program loader: framing, writes, timeout, address wrap, reset.
// Latency: outputs sampled on the falling edge, writes logged 2 time units after the rising edge.
// Backpressure: none; bytes are driven as 1-cycle strobes, back to back.
module tb_uart_prog_loader;
    localparam int TMO = 20;
`ifdef CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_prog_loader_if #(.ADDR_W(32)) bus ();
    uart_prog_loader_if #(.ADDR_W(4))  busw ();

    uart_prog_loader #(.ADDR_W(32), .BASE_ADDR(32'h100), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    uart_prog_loader #(.ADDR_W(4), .BASE_ADDR(4'hC), .TIMEOUT(TMO)) dut_w (
        .clk(clk), .reset(reset), .bus(busw)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int done_w_cnt = 0;
    int d0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  ww_addr_q[$];
    logic [31:0] ww_data_q[$];
    logic [7:0]  tx_q[$];

    // Write / done logger, offset from both clock edges
    always begin
        @(posedge clk);
        #2;
        if (bus.mem_we) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
        if (bus.load_done) done_cnt++;
        if (busw.mem_we) begin
            ww_addr_q.push_back(busw.mem_addr);
            ww_data_q.push_back(busw.mem_wdata);
        end
        if (busw.load_done) done_w_cnt++;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte strobe; called on a falling edge, returns on the next one
    task automatic send(input bit wide, input logic [7:0] b);
        if (wide) begin
            busw.rx_data  = b;
            busw.rx_valid = 1'b1;
        end else begin
            bus.rx_data  = b;
            bus.rx_valid = 1'b1;
        end
        @(negedge clk);
        bus.rx_valid  = 1'b0;
        busw.rx_valid = 1'b0;
    endtask

    // Send tx_q; bytes from index hdr on are data and feed the XOR checksum
    task automatic send_frame(input bit wide, input int hdr, input bit with_csum);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < tx_q.size(); i++) begin
            send(wide, tx_q[i]);
            if (i >= hdr) x = x ^ tx_q[i];
        end
        if (CSUM && with_csum && tx_q.size() > hdr) send(wide, x);
        tx_q.delete();
    endtask

    initial begin
        reset = 1'b0;
        bus.rx_data = 8'h00;  bus.rx_valid = 1'b0;
        busw.rx_data = 8'h00; busw.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we",    bus.mem_we, 0);
        check("rst_addr",  bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_hold",  bus.cpu_hold, 0);
        check("rst_done",  bus.load_done, 0);
        check("rst_err",   bus.load_error, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single-word frame
        wr_addr_q.delete(); wr_data_q.delete(); d0 = done_cnt;
        tx_q = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send_frame(0, 2, 1);
        repeat (3) @(negedge clk);
        check("t1_nwr",  wr_addr_q.size(), 1);
        check("t1_addr", wr_addr_q[0], 32'h100);
        check("t1_data", wr_data_q[0], 32'h0000_0013);
        check("t1_done", done_cnt - d0, 1);
        check("t1_hold", bus.cpu_hold, 0);
        check("t1_err",  bus.load_error, 0);

        // Zero-length frame
        wr_addr_q.delete(); wr_data_q.delete(); d0 = done_cnt;
        tx_q = {8'h00, 8'h00};
        send_frame(0, 2, 1);
        repeat (3) @(negedge clk);
        check("t2_nwr",  wr_addr_q.size(), 0);
        check("t2_done", done_cnt - d0, 1);
        check("t2_err",  bus.load_error, 0);
        check("t2_hold", bus.cpu_hold, 0);

        // Truncated frame times out after exactly TMO idle cycles
        wr_addr_q.delete(); wr_data_q.delete(); d0 = done_cnt;
        tx_q = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame(0, 2, 0);
        repeat (TMO - 1) @(negedge clk);
        check("t3_hold_pre", bus.cpu_hold, 1);
        check("t3_err_pre",  bus.load_error, 0);
        @(negedge clk);
        check("t3_err",  bus.load_error, 1);
        check("t3_hold", bus.cpu_hold, 0);
        repeat (3) @(negedge clk);
        check("t3_nwr",  wr_addr_q.size(), 1);
        check("t3_data", wr_data_q[0], 32'h4433_2211);
        check("t3_done", done_cnt - d0, 0);
        check("t3_err_hold", bus.load_error, 1);
        send(0, 8'h01);
        check("t3_err_clr", bus.load_error, 0);
        check("t3_hold_on", bus.cpu_hold, 1);
        tx_q = {8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_frame(0, 1, 1);
        repeat (3) @(negedge clk);
        check("t3_nwr2",  wr_addr_q.size(), 2);
        check("t3_addr2", wr_addr_q[1], 32'h100);
        check("t3_data2", wr_data_q[1], 32'h1234_5678);
        check("t3_done2", done_cnt - d0, 1);
        check("t3_err2",  bus.load_error, 0);

        // 4-bit address space: 0xC then wrap to 0x0
        ww_addr_q.delete(); ww_data_q.delete(); d0 = done_w_cnt;
        tx_q = {8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(1, 2, 1);
        repeat (3) @(negedge clk);
        check("t4_nwr",   ww_addr_q.size(), 2);
        check("t4_addr0", ww_addr_q[0], 4'hC);
        check("t4_data0", ww_data_q[0], 32'hDDCC_BBAA);
        check("t4_addr1", ww_addr_q[1], 4'h0);
        check("t4_data1", ww_data_q[1], 32'h4433_2211);
        check("t4_done",  done_w_cnt - d0, 1);

`ifdef CHECKSUM_EN
        // Matching and mismatching checksum byte
        wr_addr_q.delete(); wr_data_q.delete(); d0 = done_cnt;
        tx_q = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_frame(0, 2, 0);
        repeat (3) @(negedge clk);
        check("t5_data", wr_data_q[0], 32'hDDCC_BBAA);
        check("t5_done", done_cnt - d0, 1);
        check("t5_err",  bus.load_error, 0);
        wr_addr_q.delete(); wr_data_q.delete(); d0 = done_cnt;
        tx_q = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        send_frame(0, 2, 0);
        repeat (3) @(negedge clk);
        check("t5_nwr_bad",  wr_addr_q.size(), 1);
        check("t5_err_bad",  bus.load_error, 1);
        check("t5_done_bad", done_cnt - d0, 0);
        check("t5_hold_bad", bus.cpu_hold, 0);
`endif

        // Reset in the middle of a word
        wr_addr_q.delete(); wr_data_q.delete();
        send(0, 8'h01); send(0, 8'h00);
        send(0, 8'hAA); send(0, 8'hBB); send(0, 8'hCC);
        check("t6_hold_mid", bus.cpu_hold, 1);
        reset = 1'b0;
        #2;
        check("t6_we",    bus.mem_we, 0);
        check("t6_addr",  bus.mem_addr, 0);
        check("t6_wdata", bus.mem_wdata, 0);
        check("t6_hold",  bus.cpu_hold, 0);
        check("t6_done",  bus.load_done, 0);
        check("t6_err",   bus.load_error, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_nwr0", wr_addr_q.size(), 0);
        d0 = done_cnt;
        tx_q = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(0, 2, 1);
        repeat (3) @(negedge clk);
        check("t6_nwr",  wr_addr_q.size(), 1);
        check("t6_addr2", wr_addr_q[0], 32'h100);
        check("t6_data", wr_data_q[0], 32'hDEAD_BEEF);
        check("t6_done2", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
